// File: rtl/wb_pkg.sv
// wb_pkg: result-source encodings, writeback FSM states and register-index constants.
package wb_pkg;
    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_DM    = 2'b01,
        RES_PC4   = 2'b10,
        RES_PCIMM = 2'b11
    } result_src_e;

    typedef enum logic {
        IDLE,
        WAIT_DM
    } wb_state_e;

    localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: execute->writeback handshake, memory response and writeback/hazard outputs.
//   slave  (controller): takes the retiring instruction and dm_rsp_valid; drives in_ready, the result triple, hazard and error flags.
//   master (upstream/env): the mirror image.
interface wb_ctrl_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_result_src;
    logic            in_reg_write;
    logic [RD_W-1:0] in_rd;
    logic            dm_rsp_valid;
    logic [1:0]      result_src;
    logic            reg_write;
    logic [RD_W-1:0] rd;
    logic            pend_valid;
    logic [RD_W-1:0] pend_rd;
    logic            stall;
    logic            err_timeout;
    logic            err_spurious;

    modport slave (
        input  in_valid, in_result_src, in_reg_write, in_rd, dm_rsp_valid,
        output in_ready, result_src, reg_write, rd, pend_valid, pend_rd, stall, err_timeout, err_spurious
    );

    modport master (
        output in_valid, in_result_src, in_reg_write, in_rd, dm_rsp_valid,
        input  in_ready, result_src, reg_write, rd, pend_valid, pend_rd, stall, err_timeout, err_spurious
    );
endinterface

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller issuing registered result_src/reg_write/rd and sequencing multi-cycle loads.
//   clk, rst (async, active-high); bus: wb_ctrl_if.slave carrying the execute handshake,
//   dm_rsp_valid, the writeback triple, pending-load hazard info and timeout/spurious error pulses.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input logic       clk,
    input logic       rst,
    wb_ctrl_if.slave  bus
);
    wb_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             wen;

    assign bus.in_ready = (state == IDLE);
    assign bus.stall    = ~bus.in_ready;
    // x0 is hardwired to zero, so a write to it is dropped here rather than in the register file
    assign wen = bus.in_reg_write & (bus.in_rd != REG_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.result_src   <= RES_ALU;
            bus.reg_write    <= 1'b0;
            bus.rd           <= '0;
            bus.pend_valid   <= 1'b0;
            bus.pend_rd      <= '0;
            bus.err_timeout  <= 1'b0;
            bus.err_spurious <= 1'b0;
        end else begin
            bus.reg_write    <= 1'b0;
            bus.err_timeout  <= 1'b0;
            bus.err_spurious <= 1'b0;
            case (state)
                IDLE: begin
                    bus.err_spurious <= bus.dm_rsp_valid;
                    if (bus.in_valid && bus.in_result_src == RES_DM) begin
                        bus.pend_rd    <= bus.in_rd;
                        bus.pend_valid <= wen;
                        bus.result_src <= RES_DM;
                        cnt            <= '0;
                        state          <= WAIT_DM;
                    end else if (bus.in_valid) begin
                        bus.result_src <= bus.in_result_src;
                        bus.rd         <= bus.in_rd;
                        bus.reg_write  <= wen;
                    end
                end
                WAIT_DM: begin
                    cnt <= cnt + 1'b1;
                    // a response on the timeout cycle still completes the load
                    if (bus.dm_rsp_valid) begin
                        bus.reg_write  <= bus.pend_valid;
                        bus.result_src <= RES_DM;
                        bus.rd         <= bus.pend_rd;
                        bus.pend_valid <= 1'b0;
                        state          <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.pend_valid  <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Writeback-stage controller for the register-file write port and the result multiplexer select (ResultSrc) in the single-cycle-derived RISC-V core.
- Accepts one retiring instruction per handshake from execute.
- Issues the registered select / write-enable / destination triple to the result mux and register file.
- Sequences multi-cycle data-memory loads: holds the write until the read data is valid, and stalls upstream meanwhile.
- Exposes the pending load destination for load-use hazard detection, and flags load timeouts and spurious memory responses.

Parameters:
RD_W, 5, destination register index width
TIMEOUT, 16, max cycles waited for dm_rsp_valid before abandoning a load (range 2..255)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  execute stage presents an instruction for writeback
in_ready  out  1  controller can accept; combinational, = (state==IDLE)
in_result_src  in  2  requested result source: 00 ALU, 01 data memory, 10 PC+4, 11 PC+imm
in_reg_write  in  1  instruction writes rd
in_rd  in  RD_W  destination register index
dm_rsp_valid  in  1  data-memory read data valid this cycle (single-cycle pulse)
result_src  out  2  registered select to result mux
reg_write  out  1  registered register-file write enable (1-cycle pulse)
rd  out  RD_W  registered destination index
pend_valid  out  1  load outstanding that will write a register
pend_rd  out  RD_W  destination of the outstanding load
stall  out  1  = ~in_ready
err_timeout  out  1  1-cycle pulse when a load is abandoned
err_spurious  out  1  1-cycle pulse when dm_rsp_valid arrives in IDLE

Behaviour:
Reset (async, rst=1) forces every register to its value:
- state=IDLE, result_src=00, reg_write=0, rd=0.
- pend_valid=0, pend_rd=0, err_timeout=0, err_spurious=0, counter=0.
- Reset mid-load discards the load; no write ever issues for it.

States: IDLE, WAIT_DM.

Write qualification: wen = in_reg_write & (in_rd != 0); x0 is never written.

IDLE, accept when in_valid=1:
- in_result_src != 01: next cycle result_src=in_result_src, rd=in_rd, reg_write=wen. Latency 1. Stay IDLE.
- in_result_src == 01: capture pend_rd=in_rd and pend_valid=wen; counter=0; next state WAIT_DM.
- Next cycle after a load accept: reg_write=0, result_src=01.

IDLE, in_valid=0: reg_write=0; result_src and rd hold their last values.

WAIT_DM:
- in_ready=0; upstream holds its next instruction stable.
- Counter increments every cycle.
- dm_rsp_valid=1: next cycle reg_write=pend_valid, result_src=01, rd=pend_rd; pend_valid cleared; go IDLE. Load-to-write latency = 1 cycle after the response.
- No response and counter==TIMEOUT-1: next cycle err_timeout=1, reg_write=0, pend_valid cleared, go IDLE.
- Response and timeout in the same cycle: the response wins (write, no error).

Other boundaries:
- dm_rsp_valid in IDLE: ignored for writing; err_spurious pulses next cycle. An accept in the same cycle proceeds normally.
- Back-to-back non-load accepts every cycle: reg_write may stay high continuously with new rd/result_src each cycle.
- Load immediately after a load: the second is accepted only in the IDLE cycle after the first completes.
- reg_write is always 0 for any cycle not corresponding to an accepted write or a completed load.

Decomposition:
Package wb_pkg:
- enum result_src_e {RES_ALU=2'b00, RES_DM=2'b01, RES_PC4=2'b10, RES_PCIMM=2'b11}, shared with the result mux and decoder.
- enum wb_state_e {IDLE, WAIT_DM}.
- constant REG_ZERO=0.

No sub-module; the timeout counter is inline.

Test Plan:
- Reset mid-WAIT_DM (rd=7): assert rst -> all outputs 0 immediately, state IDLE; a later dm_rsp_valid gives err_spurious=1 and no reg_write.
- ALU write: in_valid=1, src=00, reg_write=1, rd=5 -> next cycle reg_write=1, result_src=00, rd=5, one pulse; rd=0 instead -> reg_write=0.
- Load with response 3 cycles later (rd=9): stall=1 and pend_valid=1, pend_rd=9 for 3 cycles; dm_rsp_valid -> next cycle reg_write=1, result_src=01, rd=9, in_ready=1.
- Timeout, TIMEOUT=16, no response: err_timeout pulses exactly 16 cycles after WAIT_DM entry; reg_write stays 0; then IDLE.
- Response on cycle 16 coincident with timeout -> write occurs, err_timeout=0.
- Stream ALU, PC+4, load, PC+imm with rd 1,2,3,4; load responds after 2 cycles -> writes in order 1,2,3,4 with result_src 00,10,01,11; PC+imm is held until in_ready returns.
